// File: rtl/spirw_master_if.sv
// spirw_master_if: request, payload and SPI pin bundle for spirw_master.
// master modport is the engine side, slave modport the user/pin side.
interface spirw_master_if #(
    parameter int C_ADDR_BITS = 32
);
    logic                   i_start;
    logic                   i_rd;
    logic [C_ADDR_BITS-1:0] i_addr;
    logic [15:0]            i_len;
    logic [7:0]             i_wdata;
    logic                   o_wdata_req;
    logic [7:0]             o_rdata;
    logic                   o_rdata_valid;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_csn;
    logic                   o_sclk;
    logic                   o_mosi;
    logic                   i_miso;

    modport master (
        input  i_start, i_rd, i_addr, i_len, i_wdata, i_miso,
        output o_wdata_req, o_rdata, o_rdata_valid,
        output o_busy, o_done, o_csn, o_sclk, o_mosi
    );

    modport slave (
        output i_start, i_rd, i_addr, i_len, i_wdata, i_miso,
        input  o_wdata_req, o_rdata, o_rdata_valid,
        input  o_busy, o_done, o_csn, o_sclk, o_mosi
    );
endinterface

// File: rtl/spirw_master.sv
// spirw_master: SPI mode-0 command/address/data frame engine, MSB first.
// Define SPIRW_MASTER_MISO_SYNC_EN to add a 2-flop MISO synchronizer.
module spirw_master #(
    parameter int C_CLK_DIV   = 4,
    parameter int C_ADDR_BITS = 32
) (
    input  logic            clock,
    input  logic            R_reset,
    spirw_master_if.master  bus
);
    localparam int AB = C_ADDR_BITS / 8;
    localparam int HW = C_ADDR_BITS + 8;
    localparam logic [7:0] DIV_LAST = 8'(C_CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]    state;
    logic [7:0]    div_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic [HW-1:0] hdr;
    logic [2:0]    hdr_left;
    logic [15:0]   pay_left;
    logic          rd_q;
    logic          in_pay;
    logic [7:0]    rx;
    logic          rx_last;
    logic          csn;
    logic          sclk;
    logic          busy;
    logic          done;
    logic [7:0]    rdata;
    logic          rvalid;
    logic          miso_in;

    // Sample point inside the high phase, counted from the rising edge
`ifdef SPIRW_MASTER_MISO_SYNC_EN
    localparam logic [7:0] SMP = 8'd2;
    logic miso_s1;
    logic miso_s2;

    always_ff @(posedge clock) begin
        if (R_reset) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= bus.i_miso;
            miso_s2 <= miso_s1;
        end
    end

    assign miso_in = miso_s2;
`else
    localparam logic [7:0] SMP = 8'd0;
    assign miso_in = bus.i_miso;
`endif

    logic phase_end;
    logic last_bit;
    logic hdr_next;
    logic pay_next;
    logic smp;

    assign phase_end = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_idx == 3'd7);
    assign hdr_next  = (hdr_left != 3'd0);
    assign pay_next  = !hdr_next && (pay_left != 16'd0);
    assign smp = (state == S_SHIFT) && sclk && (div_cnt == SMP)
               && in_pay && rd_q;

    assign bus.o_wdata_req = (state == S_SHIFT) && sclk && phase_end
                           && last_bit && pay_next && !rd_q;
    assign bus.o_csn         = csn;
    assign bus.o_sclk        = sclk;
    assign bus.o_mosi        = sh[7];
    assign bus.o_busy        = busy;
    assign bus.o_done        = done;
    assign bus.o_rdata       = rdata;
    assign bus.o_rdata_valid = rvalid;

    always_ff @(posedge clock) begin
        if (R_reset) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            hdr      <= '0;
            hdr_left <= '0;
            pay_left <= '0;
            rd_q     <= 1'b0;
            in_pay   <= 1'b0;
            rx       <= '0;
            rx_last  <= 1'b0;
            csn      <= 1'b1;
            sclk     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            done    <= 1'b0;
            rvalid  <= rx_last;
            rx_last <= 1'b0;
            if (rx_last) rdata <= rx;
            if (smp) begin
                rx      <= {rx[6:0], miso_in};
                rx_last <= last_bit;
            end

            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        if (bus.i_len == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= S_SETUP;
                            csn      <= 1'b0;
                            busy     <= 1'b1;
                            div_cnt  <= '0;
                            bit_idx  <= '0;
                            rd_q     <= bus.i_rd;
                            in_pay   <= 1'b0;
                            sh       <= {7'd0, bus.i_rd};
                            hdr      <= {bus.i_addr, 8'h00};
                            hdr_left <= 3'(AB) + {2'd0, bus.i_rd};
                            pay_left <= bus.i_len;
                        end
                    end
                end
                S_SETUP: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (!phase_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        // End of a high phase: advance to the next bit
                        if (sclk) begin
                            bit_idx <= bit_idx + 3'd1;
                            unique case (1'b1)
                                !last_bit: sh <= {sh[6:0], 1'b0};
                                last_bit && hdr_next: begin
                                    sh       <= hdr[HW-1 -: 8];
                                    hdr      <= {hdr[HW-9:0], 8'h00};
                                    hdr_left <= hdr_left - 3'd1;
                                end
                                last_bit && pay_next: begin
                                    sh       <= rd_q ? 8'h00 : bus.i_wdata;
                                    pay_left <= pay_left - 16'd1;
                                    in_pay   <= 1'b1;
                                end
                                default: begin
                                    sh    <= '0;
                                    state <= S_HOLD;
                                end
                            endcase
                        end
                    end
                end
                S_HOLD: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        state   <= S_IDLE;
                        csn     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
